dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Load/store unit on the MEM stage of the RV32IM pipeline. Consumes the core's data-memory request
//  (byte write-enable 0001/0011/1111 for sb/sh/sw, load strobe, funct3, address, store data) and drives
//  a valid/ready word-addressed memory bus. Aligns byte lanes, sign/zero-extends load data and stalls
//  the pipeline until the bus transaction completes. Detects misaligned accesses and bus timeouts.
// PARAMETERS
//  BUS_TIMEOUT  255  cycles in REQ+WAIT_R before abort; 8-bit counter, legal range 1..255
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  req_addr_i     in   32  byte address (ALU result, MEM stage)
//  req_wdata_i    in   32  store data, right-justified (byte/half in low bits)
//  req_we_i       in   4   0000 none, 0001 sb, 0011 sh, 1111 sw (lane-0 justified)
//  req_re_i       in   1   load request
//  req_funct3_i   in   3   load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//  stall_o        out  1   freeze PC/IF-ID/ID-EX/EX-MEM while high
//  rdata_o        out  32  extended load result, registered
//  misalign_o     out  1   one-cycle pulse on misaligned access
//  err_o          out  1   one-cycle pulse on bus timeout
//  mem_valid_o    out  1   bus request valid
//  mem_ready_i    in   1   bus accepts request
//  mem_we_o       out  1   1 write, 0 read
//  mem_addr_o     out  32  {req_addr_i[31:2],2'b00}
//  mem_be_o       out  4   byte enables
//  mem_wdata_o    out  32  lane-shifted store data
//  mem_rvalid_i   in   1   read data valid
//  mem_rdata_i    in   32  read word
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, counter=0; rdata_o=0, misalign_o=0, err_o=0, mem_valid_o=0;
//   stall_o=0 while in IDLE with no request. mem_addr/be/wdata/we are combinational from inputs.
//  Request = (req_we_i!=0) | req_re_i. Store wins if both set (load ignored).
//  Align: off=req_addr_i[1:0]; mem_be_o=req_we_i<<off (0000 for loads); mem_wdata_o=req_wdata_i<<(8*off).
//  Misaligned: half (sh/lh/lhu) with off[0]=1; word (sw/lw, funct3 010 or other) with off!=0.
//   -> no bus transaction, stall_o=0, misalign_o=1 the following cycle, rdata_o unchanged. Stays IDLE.
//  FSM:
//   IDLE   : aligned request -> stall_o=1 combinationally, mem_valid_o=1; if mem_ready_i then
//            -> DONE (store) / WAIT_R (load); else -> REQ.
//   REQ    : mem_valid_o=1, stall_o=1, all bus fields held (core holds inputs stable while stalled);
//            mem_ready_i -> DONE (store) / WAIT_R (load).
//   WAIT_R : mem_valid_o=0, stall_o=1; mem_rvalid_i -> rdata_o<=extend(mem_rdata_i), -> DONE.
//            mem_rvalid_i in the same cycle as acceptance is not taken; earliest return is next cycle.
//   DONE   : stall_o=0 for exactly one cycle (pipeline advances); -> IDLE. Request inputs ignored.
//  Extend: select byte rdata[8*off+:8] or half rdata[16*off[1]+:16]; lb/lh sign-extend,
//   lbu/lhu zero-extend, lw whole word; funct3 011/110/111 treated as lw.
//  rdata_o holds last completed load value until next load completes; stores never change it.
//  Latency: zero-wait store = 2 cycles (IDLE,DONE); zero-wait load = 3 (IDLE,WAIT_R,DONE).
//  Timeout: counter clears on entering REQ/WAIT_R, increments each cycle there; when it reaches
//   BUS_TIMEOUT -> err_o pulse, mem_valid_o=0, rdata_o<=0 (loads), -> DONE. Late mem_rvalid_i ignored.
//  misalign_o and err_o never both high; neither is sticky.
// TESTING
//  sb addr 0x1003 wdata 0x000000AB, ready=1 -> mem_be_o=1000, mem_wdata_o=0xAB000000, addr 0x1000, stall 1 cycle.
//  lh addr 0x2002, rdata 0x80011234 -> rdata_o=0xFFFF8001; lhu same -> 0x00008001; lb 0x2001 -> 0x00000012.
//  sw addr 0x3000, ready held low 3 cycles -> mem_valid_o/stall_o high 4 cycles, fields stable, then DONE.
//  sw addr 0x3002 / lh addr 0x3001 -> no mem_valid_o, stall_o=0, misalign_o pulses 1 cycle.
//  BUS_TIMEOUT=4, load, rvalid never -> err_o pulse after 4 WAIT_R cycles, rdata_o=0, stall drops next cycle.
//  rst_n low during REQ -> mem_valid_o and stall_o drop immediately; after release next request starts cleanly.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Word-addressed valid/ready data-memory bus between the load/store unit (master) and memory.
// Read data returns on a separate rvalid strobe at least one cycle after the request is accepted.
interface dmem_lsu_if;
    logic        valid;
    logic        ready;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output valid, we, addr, be, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, be, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: lane alignment, load extension, misalignment detection and a
// stalling valid/ready bus sequencer with a per-phase timeout.
module dmem_lsu #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_we_i,
    input  logic        req_re_i,
    input  logic [2:0]  req_funct3_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        err_o,
    dmem_lsu_if.master  mem
);
    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

    localparam logic [7:0] CntLast = 8'(BUS_TIMEOUT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        misalign_q;
    logic        err_q;

    logic [1:0]  off;
    logic        is_store;
    logic        is_load;
    logic        is_req;
    logic        is_word;
    logic        is_half;
    logic        misaligned;
    logic        start;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    assign off      = req_addr_i[1:0];
    assign is_store = |req_we_i;
    assign is_load  = req_re_i & ~is_store;
    assign is_req   = is_store | req_re_i;

    // Access size comes from the write enables for stores and from funct3 for loads.
    always_comb begin
        is_word = 1'b0;
        is_half = 1'b0;
        if (is_store) begin
            is_word = req_we_i[3] | req_we_i[2];
            is_half = ~is_word & req_we_i[1];
        end else begin
            is_word = req_funct3_i[1];
            is_half = (req_funct3_i[1:0] == 2'b01);
        end
    end

    assign misaligned = is_req & ((is_half & off[0]) | (is_word & (off != 2'b00)));
    assign start      = is_req & ~misaligned;

    assign byte_sel = mem.rdata[{off, 3'b000} +: 8];
    assign half_sel = mem.rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        ext_data = mem.rdata;
        unique case (req_funct3_i)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext_data = {24'b0, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext_data = {16'b0, half_sel};
            default: ext_data = mem.rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= 8'd0;
                    if (misaligned) begin
                        misalign_q <= 1'b1;
                    end else if (start) begin
                        if (mem.ready) begin
                            state_q <= is_load ? StWaitR : StDone;
                        end else begin
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    // Acceptance in the final allowed cycle still wins over the timeout.
                    if (mem.ready) begin
                        state_q <= is_load ? StWaitR : StDone;
                        cnt_q   <= 8'd0;
                    end else if (cnt_q == CntLast) begin
                        err_q   <= 1'b1;
                        state_q <= StDone;
                        if (is_load) begin
                            rdata_q <= 32'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StWaitR: begin
                    if (mem.rvalid) begin
                        rdata_q <= ext_data;
                        state_q <= StDone;
                    end else if (cnt_q == CntLast) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Gated by rst_n so an in-flight request drops off the bus the moment reset asserts.
    assign stall_o   = rst_n & (((state_q == StIdle) & start) | (state_q == StReq) |
                                (state_q == StWaitR));
    assign mem.valid = rst_n & (((state_q == StIdle) & start) | (state_q == StReq));

    assign mem.we    = is_store;
    assign mem.addr  = {req_addr_i[31:2], 2'b00};
    assign mem.be    = is_store ? (req_we_i << off) : 4'b0000;
    assign mem.wdata = req_wdata_i << {off, 3'b000};

    assign rdata_o    = rdata_q;
    assign misalign_o = misalign_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed literal vectors plus randomized transactions checked
// cycle by cycle against a transaction-level timeline model.
module tb_dmem_lsu;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_we = '0;
    logic        req_re = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        misalign;
    logic        err;

    dmem_lsu_if bus ();

    dmem_lsu #(
        .BUS_TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_we_i     (req_we),
        .req_re_i     (req_re),
        .req_funct3_i (req_funct3),
        .stall_o      (stall),
        .rdata_o      (rdata),
        .misalign_o   (misalign),
        .err_o        (err),
        .mem          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          stall;
        bit          valid;
        bit          misalign;
        bit          err;
        logic [31:0] rdata;
        bit          bus_chk;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    logic [31:0] model_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Single compare process: one expectation record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            cur = expq.pop_front();
            chk("stall_o", 32'(stall), 32'(cur.stall));
            chk("mem_valid_o", 32'(bus.valid), 32'(cur.valid));
            chk("misalign_o", 32'(misalign), 32'(cur.misalign));
            chk("err_o", 32'(err), 32'(cur.err));
            chk("rdata_o", rdata, cur.rdata);
            if (cur.bus_chk) begin
                chk("mem_we_o", 32'(bus.we), 32'(cur.we));
                chk("mem_be_o", 32'(bus.be), 32'(cur.be));
                chk("mem_addr_o", bus.addr, cur.addr);
                chk("mem_wdata_o", bus.wdata, cur.wdata);
            end
        end
    end

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] addr,
                                        input logic [31:0] w);
        int unsigned off;
        int unsigned b;
        int unsigned h;
        off = addr % 4;
        b = (w >> (8 * off)) % 256;
        h = (w >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] we, input bit re, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_we = we;
        req_re = re;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
    endtask

    // One core request; rdly = cycles until ready, vdly = cycles from acceptance to rvalid.
    task automatic run_op(input logic [3:0] we, input bit re, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input int rdly,
                          input int vdly, input logic [31:0] word, input bit noise);
        bit          is_store;
        bit          is_load;
        bit          mis;
        bit          tmo;
        int unsigned size;
        int unsigned off;
        int          vend;
        int          last;
        int          ret;
        logic [31:0] newr;
        exp_t        e;
        is_store = (we != 4'd0);
        is_load = !is_store && re;
        off = addr % 4;
        if (is_store) size = (we == 4'b1111) ? 4 : ((we == 4'b0011) ? 2 : 1);
        else size = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
        mis = (is_store || is_load) && (addr % size != 0);
        e = '{default: 0};
        e.rdata = model_rdata;
        e.we = is_store;
        e.be = is_store ? 4'((int'(we) * (2 ** off)) % 16) : 4'd0;
        e.addr = addr - off;
        e.wdata = wdata << (8 * off);
        drive_req(we, re, f3, addr, wdata);
        bus.ready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata = $urandom();
        if (!(is_store || is_load)) begin
            expq.push_back(e);
            tick();
            return;
        end
        if (mis) begin
            expq.push_back(e);
            tick();
            drive_req(4'd0, 1'b0, 3'd0, $urandom(), $urandom());
            e.misalign = 1'b1;
            expq.push_back(e);
            tick();
            return;
        end
        tmo = (rdly > int'(TO));
        vend = tmo ? int'(TO) : rdly;
        ret = -1;
        newr = model_rdata;
        if (tmo) begin
            last = int'(TO);
            if (is_load) newr = 32'd0;
        end else if (is_store) begin
            last = rdly;
        end else if (vdly > int'(TO)) begin
            tmo = 1'b1;
            last = rdly + int'(TO);
            newr = 32'd0;
            ret = rdly + vdly;
        end else begin
            last = rdly + vdly;
            ret = last;
            newr = ext(f3, addr, word);
        end
        for (int n = 0; n <= last + 1; n++) begin
            bus.ready = (n == rdly);
            bus.rvalid = (n == ret) || (noise && n == rdly);
            bus.rdata = (n == ret) ? word : $urandom();
            e.stall = (n <= last);
            e.valid = (n <= vend);
            e.bus_chk = (n <= vend);
            e.err = tmo && (n == last + 1);
            e.rdata = (n <= last) ? model_rdata : newr;
            expq.push_back(e);
            tick();
        end
        model_rdata = newr;
        bus.ready = 1'b0;
        bus.rvalid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        #4;
        chk("reset stall_o", 32'(stall), 32'd0);
        chk("reset mem_valid_o", 32'(bus.valid), 32'd0);
        chk("reset rdata_o", rdata, 32'd0);
        chk("reset misalign_o", 32'(misalign), 32'd0);
        chk("reset err_o", 32'(err), 32'd0);
        tick();

        // sb 0x1003 with zero-wait bus
        drive_req(4'b0001, 1'b0, 3'd0, 32'h0000_1003, 32'h0000_00AB);
        bus.ready = 1'b1;
        @(negedge clk);
        chk("sb mem_be_o", 32'(bus.be), 32'h8);
        chk("sb mem_wdata_o", bus.wdata, 32'hAB00_0000);
        chk("sb mem_addr_o", bus.addr, 32'h0000_1000);
        chk("sb stall cycle0", 32'(stall), 32'd1);
        @(negedge clk);
        chk("sb stall done", 32'(stall), 32'd0);
        tick();
        drive_req(4'd0, 1'b0, 3'd0, 32'd0, 32'd0);
        bus.ready = 1'b0;
        tick();

        run_op(4'd0, 1'b1, 3'b001, 32'h2002, 32'd0, 0, 1, 32'h8001_1234, 1'b0);
        chk("lh literal", rdata, 32'hFFFF_8001);
        run_op(4'd0, 1'b1, 3'b101, 32'h2002, 32'd0, 0, 1, 32'h8001_1234, 1'b0);
        chk("lhu literal", rdata, 32'h0000_8001);
        run_op(4'd0, 1'b1, 3'b000, 32'h2001, 32'd0, 0, 1, 32'h8001_1234, 1'b0);
        chk("lb literal", rdata, 32'h0000_0012);
        run_op(4'b1111, 1'b0, 3'd0, 32'h3000, 32'hCAFE_F00D, 3, 1, 32'd0, 1'b0);
        run_op(4'b1111, 1'b0, 3'd0, 32'h3002, 32'h1234_5678, 0, 1, 32'd0, 1'b0);
        run_op(4'd0, 1'b1, 3'b001, 32'h3001, 32'd0, 0, 1, 32'd0, 1'b0);
        chk("misaligned keeps rdata", rdata, 32'h0000_0012);
        run_op(4'd0, 1'b1, 3'b010, 32'h4000, 32'd0, 0, 9, 32'h5555_5555, 1'b0);
        chk("timeout rdata literal", rdata, 32'd0);

        // Reset asserted while a store sits in REQ
        drive_req(4'b1111, 1'b0, 3'd0, 32'h5000, 32'h1111_2222);
        bus.ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("reset in REQ mem_valid_o", 32'(bus.valid), 32'd0);
        chk("reset in REQ stall_o", 32'(stall), 32'd0);
        drive_req(4'd0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        rst_n = 1'b1;
        model_rdata = 32'd0;
        run_op(4'b0011, 1'b0, 3'd0, 32'h5002, 32'h0000_BEEF, 1, 1, 32'd0, 1'b0);
        run_op(4'd0, 1'b1, 3'b100, 32'h5003, 32'd0, 2, 2, 32'h9A00_0000, 1'b1);
        chk("lbu after reset", rdata, 32'h0000_009A);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] we;
            logic [2:0] f3;
            int         rdly;
            int         vdly;
            case ($urandom_range(0, 4))
                0:       we = 4'b0001;
                1:       we = 4'b0011;
                2:       we = 4'b1111;
                default: we = 4'b0000;
            endcase
            f3 = 3'($urandom_range(0, 7));
            rdly = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 6));
            vdly = ($urandom_range(0, 9) < 6) ? 1 : int'($urandom_range(2, 6));
            run_op(we, 1'($urandom_range(0, 1)), f3, $urandom(), $urandom(), rdly, vdly,
                   $urandom(), 1'($urandom_range(0, 1)));
        end
        drive_req(4'd0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL expectation queue not drained: %0d left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
